// File: rtl/arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arbiter_pkg
// Shared definitions for the pixel hit arbiter:
//   - arb_state_e        : FSM state type (IDLE, ARB, DEAD, REARM)
//   - *_DEFAULT          : default neighbour count and counter widths
//   - TIE_LOCAL_*_DEFAULT: same-cycle tie-break masks for 4 and 8 neighbours.
//     Bit i = 1 means this pixel wins a tie against neighbour i. Neighbour i
//     carries the complementary bit for this pixel, so exactly one side of
//     every pair wins a tie (lower half of the ring wins, upper half yields).
// -----------------------------------------------------------------------------
package arbiter_pkg;

  localparam int NUM_NB_DEFAULT = 8;
  localparam int WIN_W_DEFAULT  = 4;
  localparam int DEAD_W_DEFAULT = 6;

  localparam logic [7:0] TIE_LOCAL_8_DEFAULT = 8'h0F;
  localparam logic [7:0] TIE_LOCAL_4_DEFAULT = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_REARM = 2'd3
  } arb_state_e;

  // Picks the tie-break mask matching the neighbour count.
  function automatic logic [7:0] tie_local_default(input int num_nb);
    return (num_nb == 4) ? TIE_LOCAL_4_DEFAULT : TIE_LOCAL_8_DEFAULT;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing one asynchronous level into the clk domain.
// Ports:
//   clk  : destination clock
//   rstn : asynchronous active-low reset, clears both flops
//   i_d  : asynchronous input level
//   o_q  : synchronized level (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hit_arbiter_fsm.sv
// -----------------------------------------------------------------------------
// hit_arbiter_fsm
// Per-pixel hit arbiter. A rising edge of the synchronized local
// discriminator starts an event. With arbitration enabled the pixel raises
// reqToNeighbour for cfgWindow+1 cycles and then decides: it wins only if
// every present neighbour grants it (ackFromNeighbour). A dead time follows,
// and the FSM waits for the discriminator to drop before re-arming.
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   arbiterEnable       : 1 = arbitrate, 0 = bypass (every hit wins)
//   cfgWindow           : coincidence window (ARB lasts cfgWindow+1 cycles)
//   cfgDeadTime         : DEAD length is cfgDeadTime+1 cycles
//   cfgNbMask           : 1 = neighbour present, 0 = edge (ack forced to 1)
//   discOutLocal        : asynchronous local discriminator
//   reqFromNeighbour    : neighbours' registered requests
//   ackFromNeighbour    : neighbours' grants to this pixel
//   reqToNeighbour      : registered local request
//   ackToNeighbour      : registered grant to each neighbour
//   winerAll / hitLost  : one-cycle decision pulses
//   pileUp              : one-cycle pulse, hit seen while busy
// -----------------------------------------------------------------------------
module hit_arbiter_fsm
  import arbiter_pkg::*;
#(
  parameter int         NUM_NB    = NUM_NB_DEFAULT,
  parameter int         WIN_W     = WIN_W_DEFAULT,
  parameter int         DEAD_W    = DEAD_W_DEFAULT,
  parameter logic [7:0] TIE_LOCAL = tie_local_default(NUM_NB)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              arbiterEnable,
  input  logic [WIN_W-1:0]  cfgWindow,
  input  logic [DEAD_W-1:0] cfgDeadTime,
  input  logic [NUM_NB-1:0] cfgNbMask,
  input  logic              discOutLocal,
  input  logic [NUM_NB-1:0] reqFromNeighbour,
  input  logic [NUM_NB-1:0] ackFromNeighbour,
  output logic              reqToNeighbour,
  output logic [NUM_NB-1:0] ackToNeighbour,
  output logic              winerAll,
  output logic              hitLost,
  output logic              pileUp
);

  // ---------------------------------------------------------------------------
  // Hit detection
  // ---------------------------------------------------------------------------
  logic w_disc_sync;
  logic r_disc_sync_d;
  logic w_hit;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (discOutLocal),
    .o_q  (w_disc_sync)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_disc_sync_d <= 1'b0;
    end else begin
      r_disc_sync_d <= w_disc_sync;
    end
  end

  assign w_hit = w_disc_sync & ~r_disc_sync_d;

  // ---------------------------------------------------------------------------
  // Claim evaluation at the hit cycle.
  // A neighbour already requesting in the previous cycle was first, so the
  // local pixel does not claim it. A neighbour rising in this very cycle is a
  // tie, resolved by the static TIE_LOCAL bit.
  // ---------------------------------------------------------------------------
  logic [NUM_NB-1:0] r_req_nb_d;
  logic [NUM_NB-1:0] w_claim_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req_nb_d <= '0;
    end else begin
      r_req_nb_d <= reqFromNeighbour;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_NB; gi++) begin : g_claim
      assign w_claim_hit[gi] = ~r_req_nb_d[gi] &
                               (~reqFromNeighbour[gi] | TIE_LOCAL[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM state and event registers
  // ---------------------------------------------------------------------------
  arb_state_e        r_state,    w_state_next;
  logic [WIN_W-1:0]  r_win_cnt,  w_win_cnt_next;
  logic [DEAD_W-1:0] r_dead_cnt, w_dead_cnt_next;
  logic [NUM_NB-1:0] r_claim,    w_claim_next;
  logic [NUM_NB-1:0] r_nb_mask,  w_nb_mask_next;
  logic [NUM_NB-1:0] r_ack,      w_ack_next;
  logic              r_req,      w_req_next;
  logic              r_win,      w_win_next;
  logic              r_lost,     w_lost_next;
  logic              r_pile,     w_pile_next;
  logic              w_all_ack;

  // Absent (edge) neighbours count as granting.
  assign w_all_ack = &(ackFromNeighbour | ~r_nb_mask);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_win_cnt  <= '0;
      r_dead_cnt <= '0;
      r_claim    <= '0;
      r_nb_mask  <= '0;
      r_ack      <= '1;
      r_req      <= 1'b0;
      r_win      <= 1'b0;
      r_lost     <= 1'b0;
      r_pile     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_win_cnt  <= w_win_cnt_next;
      r_dead_cnt <= w_dead_cnt_next;
      r_claim    <= w_claim_next;
      r_nb_mask  <= w_nb_mask_next;
      r_ack      <= w_ack_next;
      r_req      <= w_req_next;
      r_win      <= w_win_next;
      r_lost     <= w_lost_next;
      r_pile     <= w_pile_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_win_cnt_next  = r_win_cnt;
    w_dead_cnt_next = r_dead_cnt;
    w_claim_next    = r_claim;
    w_nb_mask_next  = r_nb_mask;
    w_req_next      = r_req;
    w_win_next      = 1'b0;
    w_lost_next     = 1'b0;
    // Any new hit while an event is in progress is only reported.
    w_pile_next     = w_hit && (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          // Configuration is captured here and held for the whole event.
          w_nb_mask_next = cfgNbMask;
          if (arbiterEnable) begin
            w_state_next   = ST_ARB;
            w_req_next     = 1'b1;
            w_win_cnt_next = cfgWindow;
            w_claim_next   = w_claim_hit;
          end else begin
            w_state_next    = ST_DEAD;
            w_win_next      = 1'b1;
            w_dead_cnt_next = cfgDeadTime;
            w_claim_next    = '0;
          end
        end
      end

      ST_ARB: begin
        if (r_win_cnt == '0) begin
          w_state_next    = ST_DEAD;
          w_req_next      = 1'b0;
          w_dead_cnt_next = cfgDeadTime;
          if (w_all_ack) begin
            w_win_next = 1'b1;
          end else begin
            w_lost_next = 1'b1;
          end
        end else begin
          w_win_cnt_next = r_win_cnt - 1'b1;
        end
      end

      ST_DEAD: begin
        if (r_dead_cnt == '0) begin
          // Still-high discriminator must fall before a new hit is allowed.
          w_state_next = w_disc_sync ? ST_REARM : ST_IDLE;
        end else begin
          w_dead_cnt_next = r_dead_cnt - 1'b1;
        end
      end

      ST_REARM: begin
        if (!w_disc_sync) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Grant is withheld only from claimed neighbours, and only during ARB.
    // Derived from the next state so the registered grant lines up with it.
    w_ack_next = (w_state_next == ST_ARB) ? ~w_claim_next : '1;
  end

  assign reqToNeighbour = r_req;
  assign ackToNeighbour = r_ack;
  assign winerAll       = r_win;
  assign hitLost        = r_lost;
  assign pileUp         = r_pile;

endmodule

// File: doc/hit_arbiter_fsm.md
HIT_ARBITER_FSM -- requirements
Module: hit_arbiter_fsm

Interface
REQ-001 Parameter NUM_NB, default 8: number of neighbour pixels arbitrated against (legal 4 or 8).
REQ-002 Parameter WIN_W, default 4: width of the coincidence-window counter.
REQ-003 Parameter DEAD_W, default 6: width of the dead-time counter.
REQ-004 Parameter TIE_LOCAL, default 8'h0F: bit i=1 means local wins a same-cycle tie against neighbour i; the setting is complementary to neighbour i's own bit.
REQ-005 clk  in  1  single clock for the block.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 arbiterEnable  in  1  1 = arbitrate; 0 = bypass (every local hit wins).
REQ-008 cfgWindow  in  WIN_W  coincidence window; the ARB state lasts cfgWindow+1 cycles.
REQ-009 cfgDeadTime  in  DEAD_W  DEAD state length in cycles after a decision.
REQ-010 cfgNbMask  in  NUM_NB  1 = neighbour present; 0 = edge pixel, ack treated as 1.
REQ-011 discOutLocal  in  1  local discriminator, asynchronous to clk.
REQ-012 reqFromNeighbour  in  NUM_NB  neighbours' registered requests, clk domain.
REQ-013 ackFromNeighbour  in  NUM_NB  neighbours' grants to this pixel, clk domain.
REQ-014 reqToNeighbour  out  1  registered local request.
REQ-015 ackToNeighbour  out  NUM_NB  registered grant to neighbour i.
REQ-016 winerAll  out  1  one-cycle pulse: local hit won.
REQ-017 hitLost  out  1  one-cycle pulse: local hit lost arbitration.
REQ-018 pileUp  out  1  one-cycle pulse: local rising edge detected outside IDLE.

Function
REQ-019 discOutLocal SHALL pass through a 2-flop synchronizer; a hit is a 0->1 transition of the synchronizer output (discSync).
REQ-020 The FSM SHALL have the states IDLE, ARB, DEAD and REARM.
REQ-021 IDLE with a hit and arbiterEnable=0: winerAll pulses the next cycle, then the FSM enters DEAD.
REQ-022 IDLE with a hit and arbiterEnable=1: the FSM enters ARB, sets reqToNeighbour=1 and loads the window counter with cfgWindow.
REQ-023 The same IDLE hit SHALL latch claim[i]=1 when reqFromNeighbour[i] was 0 in the previous cycle, or rose in this same cycle with TIE_LOCAL[i]=1; otherwise claim[i]=0.
REQ-024 ackToNeighbour[i] SHALL be 0 only while in ARB with claim[i]=1; it is 1 in all other states.
REQ-025 The ARB counter SHALL decrement once per cycle; the decision is taken in the cycle the counter equals 0.
REQ-026 Win condition: &(ackFromNeighbour | ~cfgNbMask) at the decision cycle gives a winerAll pulse the next cycle; otherwise a hitLost pulse the next cycle.
REQ-027 After the decision the FSM SHALL enter DEAD, clear reqToNeighbour and load the dead counter with cfgDeadTime.
REQ-028 cfgDeadTime=0 SHALL give exactly one DEAD cycle.
REQ-029 At the end of DEAD, the FSM goes to REARM if discSync=1, else to IDLE.
REQ-030 REARM SHALL wait for discSync=0, then go to IDLE.
REQ-031 A discSync rising edge in ARB, DEAD or REARM SHALL pulse pileUp and be otherwise ignored.
REQ-032 arbiterEnable, cfgWindow and cfgNbMask SHALL be sampled only on the IDLE hit cycle; changes mid-event have no effect.
REQ-033 winerAll and hitLost SHALL never both be high, and at most one of them pulses per hit.

Reset
REQ-034 On rstn=0, state=IDLE, synchronizer flops=0, all counters=0 and claim=0, immediately and asynchronously.
REQ-035 Reset output values: reqToNeighbour=0, ackToNeighbour=all 1, winerAll=0, hitLost=0, pileUp=0.
REQ-036 Reset asserted mid-ARB SHALL abort the event with no winerAll or hitLost pulse.

Structure
REQ-037 A shared package arbiter_pkg SHALL hold the state enum type, the NUM_NB/WIN_W/DEAD_W defaults and the TIE_LOCAL default masks for 4 and 8 neighbours.
REQ-038 The 2-flop synchronizer SHALL be one sub-module, sync_2ff, instantiated once.

Verification
REQ-039 Isolated hit: enable=1, cfgWindow=3, all ackFromNeighbour=1 -> reqToNeighbour high 4 cycles, then one winerAll pulse, DEAD of cfgDeadTime+1 cycles.
REQ-040 Neighbour earlier: reqFromNeighbour[2] rises 2 cycles before the local hit, ackFromNeighbour[2]=0 -> claim[2]=0, ackToNeighbour[2] stays 1, one hitLost pulse, no winerAll.
REQ-041 Same-cycle tie with NUM_NB=8 and TIE_LOCAL=8'h0F: neighbour 1 -> ackToNeighbour[1]=0 during ARB; neighbour 5 -> ackToNeighbour[5]=1.
REQ-042 Edge pixel: cfgNbMask=8'h0F, ackFromNeighbour[7:4]=0 -> winerAll pulses.
REQ-043 Bypass and pile-up: enable=0, two hits 3 cycles apart with cfgDeadTime=10 -> one winerAll, one pileUp, reqToNeighbour stays 0.
REQ-044 Reset at the 2nd ARB cycle -> outputs at reset values at once, no decision pulse, next hit arbitrates normally.
